// File: rtl/store_load_pkg.sv
// rtl/store_load_pkg.sv - size encodings, FSM state encoding and limits shared by the store/load size paths
package store_load_pkg;

  typedef logic [1:0] store_size_t;

  localparam store_size_t SIZE_BYTE    = 2'b00;
  localparam store_size_t SIZE_HALF    = 2'b01;
  localparam store_size_t SIZE_WORD    = 2'b10;
  localparam store_size_t SIZE_ILLEGAL = 2'b11;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_READ  = 3'd1;
  localparam logic [2:0] ST_WRITE = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd3;
  localparam logic [2:0] ST_ERR   = 3'd4;

  localparam int MAX_READ_LATENCY = 7;

  function automatic logic size_is_legal(input store_size_t size);
    return size != SIZE_ILLEGAL;
  endfunction

endpackage

// File: rtl/store_lane_merge.sv
// rtl/store_lane_merge.sv - combinational lane merge of store data into an old memory word
// Lane offsets honoured only when STORE_BYTE_OFFSET_EN is defined; otherwise the low lane is always used.
module store_lane_merge
  import store_load_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] old_word,
  input  logic [DATA_W-1:0] new_data,
  input  logic [1:0]        size,
  input  logic [1:0]        offset,
  output logic [DATA_W-1:0] merged_word
);

`ifndef STORE_BYTE_OFFSET_EN
  logic unused_offset;
  assign unused_offset = ^offset;
`endif

  always_comb begin
    merged_word = old_word;
    case (size)
      SIZE_BYTE: begin
`ifdef STORE_BYTE_OFFSET_EN
        merged_word[{offset, 3'b000} +: 8] = new_data[7:0];
`else
        merged_word[7:0] = new_data[7:0];
`endif
      end
      SIZE_HALF: begin
`ifdef STORE_BYTE_OFFSET_EN
        if (offset[1]) merged_word[16 +: 16] = new_data[15:0];
        else           merged_word[0 +: 16]  = new_data[15:0];
`else
        merged_word[15:0] = new_data[15:0];
`endif
      end
      SIZE_WORD: merged_word = new_data;
      default:   merged_word = old_word;
    endcase
  end

endmodule

// File: rtl/store_rmw_unit.sv
// rtl/store_rmw_unit.sv - sb/sh/sw store unit with read-merge-write for sub-word stores
// Optional lane offsets and alignment errors under STORE_BYTE_OFFSET_EN.
module store_rmw_unit
  import store_load_pkg::*;
#(
  parameter int MEM_READ_LATENCY = 1,
  parameter int DATA_W           = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        store_size_control,
  input  logic [DATA_W-1:0] addr_in,
  input  logic [DATA_W-1:0] store_data_in,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic [DATA_W-1:0] mem_addr,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wr_data,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam logic [2:0] LAT_LAST = 3'(MEM_READ_LATENCY - 1);

  logic [2:0]        state_q, state_d;
  logic [2:0]        lat_cnt_q, lat_cnt_d;
  logic [DATA_W-1:0] merge_q, merge_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [1:0]        size_q, size_d;
  logic [DATA_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_wr_q, mem_wr_d;
  logic [DATA_W-1:0] mem_wr_data_q, mem_wr_data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic              misaligned;
  logic [DATA_W-1:0] merged_word;

  store_lane_merge #(
    .DATA_W(DATA_W)
  ) u_merge (
    .old_word   (mem_rd_data),
    .new_data   (data_q),
    .size       (size_q),
    .offset     (addr_q[1:0]),
    .merged_word(merged_word)
  );

  always_comb begin
    state_d   = state_q;
    lat_cnt_d = lat_cnt_q;
    merge_d   = merge_q;
    addr_d    = addr_q;
    data_d    = data_q;
    size_d    = size_q;

    misaligned = 1'b0;
`ifdef STORE_BYTE_OFFSET_EN
    misaligned = ((store_size_control == SIZE_HALF) && addr_in[0]) ||
                 ((store_size_control == SIZE_WORD) && (addr_in[1:0] != 2'b00));
`endif

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_d    = addr_in;
          data_d    = store_data_in;
          size_d    = store_size_control;
          lat_cnt_d = '0;
          if (!size_is_legal(store_size_control) || misaligned) state_d = ST_ERR;
          else if (store_size_control == SIZE_WORD)              state_d = ST_WRITE;
          else                                                   state_d = ST_READ;
        end
      end
      ST_READ: begin
        // Read data is only trusted on the closing edge of the last latency cycle.
        if (lat_cnt_q == LAT_LAST) begin
          merge_d = merged_word;
          state_d = ST_WRITE;
        end else begin
          lat_cnt_d = lat_cnt_q + 3'd1;
        end
      end
      ST_WRITE: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      ST_ERR:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    // Outputs are decoded from the next state so they appear registered in the state they belong to.
    mem_addr_d    = ((state_d == ST_READ) || (state_d == ST_WRITE)) ? {addr_d[DATA_W-1:2], 2'b00} : '0;
    mem_wr_d      = (state_d == ST_WRITE);
    mem_wr_data_d = '0;
    if (state_d == ST_WRITE) mem_wr_data_d = (size_d == SIZE_WORD) ? data_d : merge_d;
    busy_d        = (state_d != ST_IDLE);
    done_d        = (state_d == ST_DONE);
    error_d       = (state_d == ST_ERR);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      lat_cnt_q     <= '0;
      merge_q       <= '0;
      addr_q        <= '0;
      data_q        <= '0;
      size_q        <= '0;
      mem_addr_q    <= '0;
      mem_wr_q      <= 1'b0;
      mem_wr_data_q <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      lat_cnt_q     <= lat_cnt_d;
      merge_q       <= merge_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
      size_q        <= size_d;
      mem_addr_q    <= mem_addr_d;
      mem_wr_q      <= mem_wr_d;
      mem_wr_data_q <= mem_wr_data_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      error_q       <= error_d;
    end
  end

  assign mem_addr    = mem_addr_q;
  assign mem_wr      = mem_wr_q;
  assign mem_wr_data = mem_wr_data_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = error_q;

endmodule

// File: tb/tb_store_rmw_unit.sv
// tb/tb_store_rmw_unit.sv - bench for store_rmw_unit at read latencies 1 and 3
module tb_store_rmw_unit;

  localparam int LAT_A = 1;
  localparam int LAT_B = 3;

  typedef struct {
    bit          is_err;
    logic [31:0] addr;
    logic [31:0] wdata;
  } exp_t;

  typedef struct {
    logic [1:0]  sz;
    logic [31:0] ad;
    logic [31:0] dt;
    logic [31:0] mw;
    bit          err;
    logic [31:0] ea;
    logic [31:0] ewd;
  } vec_t;

  logic        clk;
  logic        reset;
  logic        start_a, start_b;
  logic [1:0]  size;
  logic [31:0] addr, data, mem_word;
  logic [31:0] rd_a, rd_b;
  logic [31:0] mem_addr_a, mem_addr_b, mem_wr_data_a, mem_wr_data_b;
  logic        mem_wr_a, mem_wr_b, busy_a, busy_b, done_a, done_b, error_a, error_b;

  int checks = 0;
  int errors = 0;
  int cnt_a, cnt_b;
  exp_t q_a[$];
  exp_t q_b[$];
  exp_t ea, eb;
  vec_t vt[10];

  store_rmw_unit #(.MEM_READ_LATENCY(LAT_A), .DATA_W(32)) u_dut_a (
    .clk(clk), .reset(reset), .start(start_a), .store_size_control(size),
    .addr_in(addr), .store_data_in(data), .mem_rd_data(rd_a),
    .mem_addr(mem_addr_a), .mem_wr(mem_wr_a), .mem_wr_data(mem_wr_data_a),
    .busy(busy_a), .done(done_a), .error(error_a)
  );

  store_rmw_unit #(.MEM_READ_LATENCY(LAT_B), .DATA_W(32)) u_dut_b (
    .clk(clk), .reset(reset), .start(start_b), .store_size_control(size),
    .addr_in(addr), .store_data_in(data), .mem_rd_data(rd_b),
    .mem_addr(mem_addr_b), .mem_wr(mem_wr_b), .mem_wr_data(mem_wr_data_b),
    .busy(busy_b), .done(done_b), .error(error_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory returns garbage until the read address has been held for the latency.
  wire rd_phase_a = busy_a & ~mem_wr_a & ~done_a & ~error_a;
  wire rd_phase_b = busy_b & ~mem_wr_b & ~done_b & ~error_b;
  assign rd_a = (rd_phase_a && cnt_a >= LAT_A - 1) ? mem_word : 32'hBAD0_BAD0;
  assign rd_b = (rd_phase_b && cnt_b >= LAT_B - 1) ? mem_word : 32'hBAD0_BAD0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_a <= 0;
      cnt_b <= 0;
    end else begin
      cnt_a <= rd_phase_a ? cnt_a + 1 : 0;
      cnt_b <= rd_phase_b ? cnt_b + 1 : 0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mem_wr_a || error_a) begin
      if (q_a.size() == 0) begin
        chk("sb_a_unexpected_access", {mem_wr_a, error_a}, 32'h0);
      end else begin
        ea = q_a.pop_front();
        chk("sb_a_error", 32'(error_a), 32'(ea.is_err));
        chk("sb_a_wr", 32'(mem_wr_a), 32'(!ea.is_err));
        if (!ea.is_err) begin
          chk("sb_a_addr", mem_addr_a, ea.addr);
          chk("sb_a_wdata", mem_wr_data_a, ea.wdata);
        end
      end
    end
    if (mem_wr_b || error_b) begin
      if (q_b.size() == 0) begin
        chk("sb_b_unexpected_access", {mem_wr_b, error_b}, 32'h0);
      end else begin
        eb = q_b.pop_front();
        chk("sb_b_error", 32'(error_b), 32'(eb.is_err));
        chk("sb_b_wr", 32'(mem_wr_b), 32'(!eb.is_err));
        if (!eb.is_err) begin
          chk("sb_b_addr", mem_addr_b, eb.addr);
          chk("sb_b_wdata", mem_wr_data_b, eb.wdata);
        end
      end
    end
  end

  task automatic run_op(input bit sel, input logic [1:0] sz, input logic [31:0] ad,
                        input logic [31:0] dt, input logic [31:0] mw, input bit exp_err,
                        input logic [31:0] exp_ad, input logic [31:0] exp_wd,
                        input bit poke, input string tag);
    int   wr_cyc, done_cyc, err_cyc, lat, exp_wr, exp_done, exp_errc;
    exp_t e;
    lat = sel ? LAT_B : LAT_A;
    @(negedge clk);
    size = sz; addr = ad; data = dt; mem_word = mw;
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    e.is_err = exp_err; e.addr = exp_ad; e.wdata = exp_wd;
    if (sel) q_b.push_back(e); else q_a.push_back(e);
    wr_cyc = -1; done_cyc = -1; err_cyc = -1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (!poke) begin start_a = 1'b0; start_b = 1'b0; end
      addr = $urandom; data = $urandom; size = 2'($urandom);
      if ((sel ? mem_wr_b : mem_wr_a) && wr_cyc < 0) wr_cyc = c;
      if (sel ? done_b : done_a) done_cyc = c;
      if (sel ? error_b : error_a) err_cyc = c;
      if (done_cyc > 0 || err_cyc > 0) break;
    end
    if (exp_err)             begin exp_wr = -1;      exp_done = -1;      exp_errc = 1;  end
    else if (sz == 2'b10)    begin exp_wr = 1;       exp_done = 2;       exp_errc = -1; end
    else                     begin exp_wr = 1 + lat; exp_done = 2 + lat; exp_errc = -1; end
    chk({tag, "_wr_cycle"}, 32'(wr_cyc), 32'(exp_wr));
    chk({tag, "_done_cycle"}, 32'(done_cyc), 32'(exp_done));
    chk({tag, "_err_cycle"}, 32'(err_cyc), 32'(exp_errc));
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0;
    chk({tag, "_idle_after"}, 32'(sel ? busy_b : busy_a), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1);
  end

  initial begin
    vt[0] = '{2'b10, 32'h0000_0010, 32'hDEAD_BEEF, 32'h1122_3344, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF};
    vt[1] = '{2'b00, 32'h0000_0020, 32'hAABB_CCDD, 32'h1122_3344, 1'b0, 32'h0000_0020, 32'h1122_33DD};
    vt[2] = '{2'b01, 32'h0000_0024, 32'h0000_BEEF, 32'h1122_3344, 1'b0, 32'h0000_0024, 32'h1122_BEEF};
    vt[3] = '{2'b11, 32'h0000_0030, 32'h1234_5678, 32'h1122_3344, 1'b1, 32'h0, 32'h0};
    vt[8] = '{2'b00, 32'hFFFF_FFFC, 32'h0000_0080, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFC, 32'hFFFF_FF80};
`ifdef STORE_BYTE_OFFSET_EN
    vt[4] = '{2'b00, 32'h0000_0013, 32'h0000_00EE, 32'h1122_3344, 1'b0, 32'h0000_0010, 32'hEE22_3344};
    vt[5] = '{2'b01, 32'h0000_0011, 32'h0000_5555, 32'h1122_3344, 1'b1, 32'h0, 32'h0};
    vt[6] = '{2'b10, 32'h0000_0006, 32'h0123_4567, 32'h1122_3344, 1'b1, 32'h0, 32'h0};
    vt[7] = '{2'b01, 32'h0000_0012, 32'hCAFE_F00D, 32'hAABB_CCDD, 1'b0, 32'h0000_0010, 32'hF00D_CCDD};
    vt[9] = '{2'b00, 32'h0000_0041, 32'h0000_0012, 32'h0000_0000, 1'b0, 32'h0000_0040, 32'h0000_1200};
`else
    vt[4] = '{2'b00, 32'h0000_0013, 32'h0000_00EE, 32'h1122_3344, 1'b0, 32'h0000_0010, 32'h1122_33EE};
    vt[5] = '{2'b01, 32'h0000_0011, 32'h0000_5555, 32'h1122_3344, 1'b0, 32'h0000_0010, 32'h1122_5555};
    vt[6] = '{2'b10, 32'h0000_0006, 32'h0123_4567, 32'h1122_3344, 1'b0, 32'h0000_0004, 32'h0123_4567};
    vt[7] = '{2'b01, 32'h0000_0012, 32'hCAFE_F00D, 32'hAABB_CCDD, 1'b0, 32'h0000_0010, 32'hAABB_F00D};
    vt[9] = '{2'b00, 32'h0000_0041, 32'h0000_0012, 32'h0000_0000, 1'b0, 32'h0000_0040, 32'h0000_0012};
`endif

    reset = 1'b1; start_a = 1'b0; start_b = 1'b0;
    size = 2'b00; addr = '0; data = '0; mem_word = '0;
    @(negedge clk);
    chk("reset_mem_addr", mem_addr_a, 32'h0);
    chk("reset_mem_wr", {31'h0, mem_wr_a}, 32'h0);
    chk("reset_mem_wr_data", mem_wr_data_a, 32'h0);
    chk("reset_flags_a", {29'h0, busy_a, done_a, error_a}, 32'h0);
    chk("reset_flags_b", {28'h0, mem_wr_b, busy_b, done_b, error_b}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_no_start", {29'h0, busy_a, done_a, error_a}, 32'h0);

    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 10; i++) begin
        run_op(s[0], vt[i].sz, vt[i].ad, vt[i].dt, vt[i].mw, vt[i].err, vt[i].ea, vt[i].ewd,
               1'b0, $sformatf("vec%0d_dut%0d", i, s));
      end
    end

    // Half store at latency 3 with start held high while busy and through the DONE cycle.
    run_op(1'b1, 2'b01, 32'h0000_0024, 32'h0000_BEEF, 32'h1122_3344, 1'b0,
           32'h0000_0024, 32'h1122_BEEF, 1'b1, "half_poke");

    // Illegal size, then a word store accepted in the cycle right after ERR.
    @(negedge clk);
    size = 2'b11; addr = 32'h80; data = 32'h1; start_a = 1'b1;
    q_a.push_back('{1'b1, 32'h0, 32'h0});
    @(negedge clk);
    start_a = 1'b0;
    chk("err_pulse", {30'h0, error_a, busy_a}, 32'h3);
    chk("err_no_done", {31'h0, done_a}, 32'h0);
    @(negedge clk);
    chk("err_one_cycle", {30'h0, error_a, busy_a}, 32'h0);
    size = 2'b10; addr = 32'h0000_0100; data = 32'h5A5A_0F0F; start_a = 1'b1;
    q_a.push_back('{1'b0, 32'h0000_0100, 32'h5A5A_0F0F});
    @(negedge clk);
    start_a = 1'b0;
    chk("after_err_wr", {31'h0, mem_wr_a}, 32'h1);
    @(negedge clk);
    chk("after_err_done", {31'h0, done_a}, 32'h1);

    // Reset in the middle of READ on the latency-3 unit.
    @(negedge clk);
    size = 2'b00; addr = 32'h0000_0200; data = 32'h0000_0077; mem_word = 32'h8888_8888; start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    @(negedge clk);
    chk("rst_mid_in_read", {30'h0, busy_b, mem_wr_b}, 32'h2);
    chk("rst_mid_read_addr", mem_addr_b, 32'h0000_0200);
    #1 reset = 1'b1;
    #1;
    chk("rst_mid_flags", {28'h0, mem_wr_b, busy_b, done_b, error_b}, 32'h0);
    chk("rst_mid_addr", mem_addr_b, 32'h0);
    chk("rst_mid_wdata", mem_wr_data_b, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_mid_stays_idle", {30'h0, busy_b, mem_wr_b}, 32'h0);
    run_op(1'b1, 2'b10, 32'h0000_0300, 32'hCAFE_BABE, 32'h0, 1'b0,
           32'h0000_0300, 32'hCAFE_BABE, 1'b0, "post_reset_word");

    repeat (3) @(negedge clk);
    chk("sb_a_drained", 32'(q_a.size()), 32'h0);
    chk("sb_b_drained", 32'(q_b.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
